fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, maximum in-flight imem requests (1..DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-007 SHALL have port imem_req_addr  out  32  fetch address.
REQ-008 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-009 SHALL have port imem_resp_valid  in  1  in-order response valid, no backpressure.
REQ-010 SHALL have port imem_resp_data  in  32  fetched instruction.
REQ-011 SHALL have port redirect_valid  in  1  branch/jump flush request.
REQ-012 SHALL have port redirect_pc  in  32  new fetch PC.
REQ-013 SHALL have port out_valid  out  1  head entry valid toward decode.
REQ-014 SHALL have port out_instr  out  32  head instruction.
REQ-015 SHALL have port out_pc  out  32  head instruction PC.
REQ-016 SHALL have port out_ready  in  1  decode accepts (low = core stall).

Function
REQ-017 SHALL assert imem_req_valid iff no redirect this cycle, count+outstanding<DEPTH and outstanding<MAX_OUTSTANDING; imem_req_addr = fetch_pc.
REQ-018 SHALL increment fetch_pc by 4 (mod 2^32, wraps 32'hFFFF_FFFC->0) on imem_req_valid & imem_req_ready.
REQ-019 SHALL, with drop_cnt==0, push {resp_pc, imem_resp_data} on imem_resp_valid and advance resp_pc by 4; credit rule guarantees no overflow.
REQ-020 SHALL, with drop_cnt>0, discard the response and decrement drop_cnt.
REQ-021 SHALL drive out_valid = (count!=0) from registers only; out_instr/out_pc = head; pop on out_valid & out_ready; out_ready ignored when out_valid=0.
REQ-022 SHALL support simultaneous push and pop, count unchanged.
REQ-023 SHALL give redirect priority: next cycle count=0, out_valid=0, fetch_pc=resp_pc=redirect_pc, drop_cnt = outstanding after this cycle's response (pop/push suppressed).
REQ-024 SHALL keep two states: RUN (drop_cnt==0) and DRAIN (drop_cnt>0); RUN->DRAIN on redirect with nonzero in-flight count, DRAIN->RUN when last stale response is dropped; new requests may issue in DRAIN.
REQ-025 SHALL handle back-to-back redirects: the latest redirect_pc wins; drop_cnt recomputed each time.
REQ-026 SHALL produce first instruction on out_valid no earlier than 2 cycles after the first request handshake (one-cycle memory).

Reset
REQ-027 SHALL asynchronously clear count, outstanding, drop_cnt, out_valid=0, imem_req_valid=0, fetch_pc=resp_pc=RESET_PC.
REQ-028 SHALL issue first request in the first cycle after rst_n deasserts; memory is reset together, so no stale responses after reset.

Configuration
REQ-029 SHALL, with FETCH_QUEUE_PERF_EN defined, add outputs perf_bubble_cnt[31:0] (cycles out_valid=0 and no redirect) and perf_redirect_cnt[31:0], reset to 0, saturating at 32'hFFFF_FFFF.
REQ-030 SHALL, without FETCH_QUEUE_PERF_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-031 SHALL take XLEN=32, RESET_PC default and NOP encoding 32'h0000_0013 from shared package cpu_pkg.
REQ-032 SHALL instantiate one sub-module fetch_fifo (synchronous {pc,instr} FIFO with push/pop/flush, count output).

Verification
REQ-033 Reset, memory always ready, out_ready=1 -> out_pc sequence 0,4,8,12 with matching words, one per cycle in steady state.
REQ-034 out_ready=0 for 10 cycles -> count saturates at 4, imem_req_valid=0, no entry lost; release -> PCs continue from 0 in order.
REQ-035 Redirect to 32'h0000_0100 with 2 requests in flight -> both responses dropped, next out_pc=32'h100, no old PC emitted.
REQ-036 Redirects on two consecutive cycles (0x200 then 0x300) -> first out_pc=0x300.
REQ-037 fetch_pc=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst_n asserted mid-stream with count=3 -> out_valid=0 immediately, refetch from RESET_PC; with FETCH_QUEUE_PERF_EN, counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core-wide constants (XLEN, reset PC, NOP encoding)
package cpu_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - fetch queue types: flush state, queue entry, PC step helper
package fetch_queue_pkg;

    import cpu_pkg::*;

    // RUN: responses are kept; DRAIN: responses from before a redirect are discarded
    typedef enum logic {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Sequential PC advance; wraps naturally at 2^32
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue bus: imem request/response, redirect, decode output
interface fetch_queue_if;

    import cpu_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_ready;

    // Fetch queue side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    // Memory / core side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc,instr} FIFO with push, pop, flush and count
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output fq_entry_t     head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Entry storage; contents only matter while count marks them live
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue in a single cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with credit-limited imem requests and redirect flush; FETCH_QUEUE_PERF_EN adds perf counters
module fetch_queue
    import cpu_pkg::*;
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]   perf_bubble_cnt,
    output logic [31:0]   perf_redirect_cnt,
`endif
    fetch_queue_if.master bus
);

    localparam int            CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUTSTANDING);

    fq_state_e       state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight_after;
    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            out_valid_int;
    fq_entry_t       head;
    fq_entry_t       push_entry;

    // Every in-flight request owns a queue slot, so a response can always be pushed.
    // rst_n gates the request so nothing is offered while memory is held in reset.
    assign occupancy          = {1'b0, fifo_count} + {1'b0, outstanding};
    assign bus.imem_req_valid = rst_n && !bus.redirect_valid &&
                                (occupancy < DEPTH_W) && (outstanding < MAX_OUT_W);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign out_valid_int  = (fifo_count != '0);
    assign push           = bus.imem_resp_valid && (state == FQ_RUN) && !bus.redirect_valid;
    assign pop            = out_valid_int && bus.out_ready && !bus.redirect_valid;
    assign inflight_after = outstanding - CW'(bus.imem_resp_valid);
    assign push_entry     = '{pc: resp_pc, instr: bus.imem_resp_data};

    // Fetch/response PCs, in-flight credit count and the RUN/DRAIN flush state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FQ_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({req_fire, bus.imem_resp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
                resp_pc  <= bus.redirect_pc;
                drop_cnt <= inflight_after;
                state    <= (inflight_after != '0) ? FQ_DRAIN : FQ_RUN;
            end else begin
                if (req_fire) begin
                    fetch_pc <= next_pc(fetch_pc);
                end
                if (push) begin
                    resp_pc <= next_pc(resp_pc);
                end
                if ((state == FQ_DRAIN) && bus.imem_resp_valid) begin
                    drop_cnt <= drop_cnt - CW'(1);
                    if (drop_cnt == CW'(1)) begin
                        state <= FQ_RUN;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign bus.out_valid = out_valid_int;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = out_valid_int ? head.instr : NOP_INSTR;

`ifdef FETCH_QUEUE_PERF_EN
    // Bubble and redirect counters, saturating so long runs never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt   <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (!out_valid_int && !bus.redirect_valid && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
            if (bus.redirect_valid && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with an in-order variable-latency memory model
module tb_fetch_queue;

    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_queue_if bus ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    fetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
`ifdef FETCH_QUEUE_PERF_EN
        .perf_bubble_cnt   (perf_bubble_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
`endif
        .bus               (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          due;
        int          epoch;
    } mem_ent_t;

    mem_ent_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] model_pc;
    int total, bad, cyc, epoch, mem_lat, pops;
    int first_fire_cyc, first_out_cyc, rel_cyc;
    int exp_bubbles, exp_redirs;
    int n, idx, p0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b0;
    endtask

    // Called at a negedge; memory and queue are reset together
    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_req_valid", bus.imem_req_valid, 0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst_perf_bubble", perf_bubble_cnt, 0);
        chk("rst_perf_redirect", perf_redirect_cnt, 0);
`endif
        mem_q.delete();
        exp_q.delete();
        pop_log.delete();
        model_pc       = 32'h0000_0000;
        epoch++;
        first_fire_cyc = -1;
        first_out_cyc  = -1;
        exp_bubbles    = 0;
        exp_redirs     = 0;
        repeat (hold) @(negedge clk);
        cyc   += hold;
        rst_n  = 1'b1;
        rel_cyc = cyc;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, update models, wait next negedge
    task automatic tick(input logic rdy, input logic ordy, input logic redir, input logic [31:0] rpc);
        logic        resp_now;
        logic        exp_req;
        int          out_m;
        mem_ent_t    ent;
        logic [31:0] epc;
        resp_now            = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
            ent                 = mem_q.pop_front();
            resp_now            = 1'b1;
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = ent.data;
        end
        bus.imem_req_ready = rdy;
        bus.out_ready      = ordy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        out_m   = mem_q.size() + (resp_now ? 1 : 0);
        exp_req = !redir && ((exp_q.size() + out_m) < DEPTH) && (out_m < MAXO);
        chk("req_valid", bus.imem_req_valid, exp_req);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (!bus.out_valid && !redir) exp_bubbles++;
        if (redir) exp_redirs++;
        if (bus.out_valid && ordy && !redir) begin
            pops++;
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                epc = exp_q.pop_front();
                chk("out_pc", bus.out_pc, epc);
                chk("out_instr", bus.out_instr, word_of(epc));
            end
            pop_log.push_back(bus.out_pc);
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            model_pc = rpc;
        end
        if (resp_now && ent.epoch == epoch) exp_q.push_back(ent.pc);
        if (bus.imem_req_valid && rdy) begin
            chk("req_addr", bus.imem_req_addr, model_pc);
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
            mem_q.push_back('{pc: model_pc, data: word_of(bus.imem_req_addr),
                              due: cyc + mem_lat, epoch: epoch});
            model_pc = model_pc + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Stop new fetches and let everything in flight reach decode
    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && k < 60) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            k++;
        end
        chk("drain_done", exp_q.size() + mem_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cyc = 0; epoch = 0; mem_lat = 1; pops = 0;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);

        // Streaming with always-ready memory and decode
        apply_reset(3);
        repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("first_req_cycle", first_fire_cyc, rel_cyc);
        chk("first_out_latency_ge2", (first_out_cyc - first_fire_cyc) >= 2, 1);
        chk("stream_pops", pop_log.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_log.size()) chk("stream_pc", pop_log[i], 32'(i * 4));
        end
        p0 = pops;
        repeat (10) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("steady_rate", pops - p0, 10);
        drain();

        // Decode stall fills the queue and stops fetch, nothing lost on release
        apply_reset(2);
        repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_full", exp_q.size(), DEPTH);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_no_req", bus.imem_req_valid, 0);
        repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_resume_pc", pop_log[0], 32'h0);
        drain();

        // Redirect with two requests in flight (two-cycle memory)
        mem_lat = 2;
        n = 0;
        while (mem_q.size() != 2 && n < 10) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("inflight_before_redirect", mem_q.size(), 2);
        idx = pop_log.size();
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        chk("redirect_clears_out", bus.out_valid, 0);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);
        drain();
        chk("redirect_first_pc", pop_log[idx], 32'h0000_0100);

        // Back-to-back redirects: the later target wins
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
        idx = pop_log.size();
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);
        drain();
        chk("b2b_first_pc", pop_log[idx], 32'h0000_0300);

        // Fetch PC wraps across 2^32
        idx = pop_log.size();
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
        drain();
        chk("wrap_pc0", pop_log[idx], 32'hFFFF_FFF8);
        chk("wrap_pc1", pop_log[idx + 1], 32'hFFFF_FFFC);
        chk("wrap_pc2", pop_log[idx + 2], 32'h0000_0000);

        // Random ready/stall/redirect mix
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC);
        end
        drain();
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_bubbles", perf_bubble_cnt, exp_bubbles);
        chk("perf_redirects", perf_redirect_cnt, exp_redirs);
`endif

        // Reset mid-stream with three entries queued
        mem_lat = 1;
        apply_reset(2);
        n = 0;
        while (exp_q.size() != 3 && n < 20) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            n++;
        end
        chk("count3_reached", exp_q.size(), 3);
        apply_reset(2);
        repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("refetch_pc", pop_log[0], 32'h0000_0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
